// File: rtl/nbuf_ctrl_if.sv
// Writer/reader frame handshake bundle for nbuf_ctrl.
// master = frame clients (writer and reader), slave = the controller.
interface nbuf_ctrl_if;
  logic        wr_sync;
  logic        wr_frame_ready;
  logic        wr_frame_valid;
  logic        wr_frame_done;
  logic [31:0] wr_BUF_ADDR;
  logic [31:0] wr_FRAME_BYTES;
  logic        rd_sync;
  logic        rd_frame_ready;
  logic        rd_frame_valid;
  logic        rd_frame_done;
  logic [31:0] rd_BUF_ADDR;
  logic [31:0] rd_FRAME_BYTES;

  modport master (
    output wr_sync, wr_frame_ready, rd_sync, rd_frame_ready,
    input  wr_frame_valid, wr_frame_done, wr_BUF_ADDR, wr_FRAME_BYTES,
    input  rd_frame_valid, rd_frame_done, rd_BUF_ADDR, rd_FRAME_BYTES
  );

  modport slave (
    input  wr_sync, wr_frame_ready, rd_sync, rd_frame_ready,
    output wr_frame_valid, wr_frame_done, wr_BUF_ADDR, wr_FRAME_BYTES,
    output rd_frame_valid, rd_frame_done, rd_BUF_ADDR, rd_FRAME_BYTES
  );
endinterface

// File: rtl/nbuf_ctrl.sv
// N-buffer frame controller: hands DRAM frame buffers between one writer and one
// reader, in latest-frame (MODE=0, drops stale frames) or FIFO (MODE=1) order.
module nbuf_ctrl #(
  parameter int NBUF  = 3,
  parameter int MODE  = 0,
  parameter int CNT_W = 16,
  parameter int IDX_W = $clog2(NBUF)
) (
  input  logic              fclk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       FRAME_BYTES,
  input  logic [31:0]       BUF_BASE,
  nbuf_ctrl_if.slave        bus,
  output logic [CNT_W-1:0]  drop_count,
  output logic [CNT_W-1:0]  underrun_count,
  output logic [IDX_W:0]    ready_count
);

  generate
    if (MODE < 0 || MODE > 1 || NBUF > 8 || (MODE == 0 && NBUF < 3) || (MODE == 1 && NBUF < 2)) begin : g_bad_param
      $error("nbuf_ctrl: NBUF/MODE combination out of range");
    end
  endgenerate

  typedef enum logic [1:0] {ST_STOPPED, ST_WAIT, ST_WORKING} fsm_e;
  typedef enum logic [1:0] {B_FREE, B_WRITING, B_READY, B_READING} buf_e;

  fsm_e             wr_cs, rd_cs;
  logic [IDX_W-1:0] wr_ptr_q, rd_ptr_q;
  buf_e             buf_st_q [NBUF];

  logic [IDX_W-1:0] q_mem_q [NBUF];
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [CNT_W-1:0] drop_q, drop_d, underrun_q;

  logic             free_any;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] head_idx;
  logic             wr_grant, wr_done, rd_grant, rd_done, rd_underrun, flush;

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(NBUF - 1)) ? '0 : p + 1'b1;
  endfunction

  // Lowest-index FREE buffer wins the writer grant.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NBUF - 1; i >= 0; i--) begin
      if (buf_st_q[i] == B_FREE) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign head_idx    = q_mem_q[head_q];
  assign wr_grant    = (wr_cs == ST_WAIT) && bus.wr_sync && bus.wr_frame_ready && free_any;
  assign wr_done     = (wr_cs == ST_WORKING) && bus.wr_frame_ready;
  assign rd_grant    = (rd_cs == ST_WAIT) && bus.rd_sync && bus.rd_frame_ready && (count_q != '0);
  assign rd_underrun = (rd_cs == ST_WAIT) && bus.rd_sync && bus.rd_frame_ready && (count_q == '0);
  assign rd_done     = (rd_cs == ST_WORKING) && bus.rd_frame_ready;
  assign flush       = (MODE == 0) && wr_done;

  assign bus.wr_frame_valid = wr_grant;
  assign bus.wr_frame_done  = wr_done;
  assign bus.rd_frame_valid = rd_grant;
  assign bus.rd_frame_done  = rd_done;
  assign bus.wr_BUF_ADDR    = BUF_BASE + 32'(wr_ptr_q) * FRAME_BYTES;
  assign bus.rd_BUF_ADDR    = BUF_BASE + 32'(rd_ptr_q) * FRAME_BYTES;
  assign bus.wr_FRAME_BYTES = FRAME_BYTES;
  assign bus.rd_FRAME_BYTES = FRAME_BYTES;
  assign drop_count         = drop_q;
  assign underrun_count     = underrun_q;
  assign ready_count        = count_q;

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      wr_cs    <= ST_STOPPED;
      wr_ptr_q <= '0;
    end else begin
      case (wr_cs)
        ST_STOPPED: if (start) wr_cs <= ST_WAIT;
        ST_WAIT: begin
          if (wr_grant) begin
            wr_cs    <= ST_WORKING;
            wr_ptr_q <= free_idx;
          end else if (!start) begin
            wr_cs <= ST_STOPPED;
          end
        end
        ST_WORKING: if (bus.wr_frame_ready) wr_cs <= start ? ST_WAIT : ST_STOPPED;
        default: wr_cs <= ST_STOPPED;
      endcase
    end
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      rd_cs    <= ST_STOPPED;
      rd_ptr_q <= '0;
    end else begin
      case (rd_cs)
        ST_STOPPED: if (start) rd_cs <= ST_WAIT;
        ST_WAIT: begin
          if (rd_grant) begin
            rd_cs    <= ST_WORKING;
            rd_ptr_q <= head_idx;
          end else if (!start) begin
            rd_cs <= ST_STOPPED;
          end
        end
        ST_WORKING: if (bus.rd_frame_ready) rd_cs <= start ? ST_WAIT : ST_STOPPED;
        default: rd_cs <= ST_STOPPED;
      endcase
    end
  end

  // Events on one buffer never collide except the flush, which yields to the pop.
  genvar gi;
  generate
    for (gi = 0; gi < NBUF; gi++) begin : g_buf
      always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
          buf_st_q[gi] <= B_FREE;
        end else if (wr_grant && free_idx == IDX_W'(gi)) begin
          buf_st_q[gi] <= B_WRITING;
        end else if (wr_done && wr_ptr_q == IDX_W'(gi)) begin
          buf_st_q[gi] <= B_READY;
        end else if (rd_grant && head_idx == IDX_W'(gi)) begin
          buf_st_q[gi] <= B_READING;
        end else if (rd_done && rd_ptr_q == IDX_W'(gi)) begin
          buf_st_q[gi] <= B_FREE;
        end else if (flush && buf_st_q[gi] == B_READY) begin
          buf_st_q[gi] <= B_FREE;
        end
      end
    end
  endgenerate

  always_ff @(posedge fclk) begin
    if (wr_done) q_mem_q[tail_q] <= wr_ptr_q;
  end

  // A latest-frame push discards whatever survived the pop and restarts the queue at tail.
  always_comb begin
    head_d  = rd_grant ? ptr_inc(head_q) : head_q;
    tail_d  = wr_done ? ptr_inc(tail_q) : tail_q;
    count_d = count_q + (IDX_W+1)'(wr_done) - (IDX_W+1)'(rd_grant);
    drop_d  = drop_q;
    if (flush) begin
      head_d  = tail_q;
      count_d = (IDX_W+1)'(1);
      drop_d  = drop_q + CNT_W'(count_q) - CNT_W'(rd_grant);
    end
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      underrun_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      if (rd_underrun) underrun_q <= underrun_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_nbuf_ctrl.sv
// Directed vector bench for nbuf_ctrl: a MODE=0/NBUF=3 and a MODE=1/NBUF=4 instance
// driven from per-cycle tables, plus a hand-written asynchronous reset sequence.
module tb_nbuf_ctrl;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] FB   = 32'h0004_B000;
  localparam logic [31:0] A0   = 32'h1000_0000;
  localparam logic [31:0] A1   = 32'h1004_B000;
  localparam logic [31:0] A2   = 32'h1009_6000;
  localparam logic [31:0] A3   = 32'h100E_1000;

  logic fclk = 1'b0;
  logic rst  = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [15:0] drop0, ur0, drop1, ur1;
  logic [2:0]  rc0, rc1;

  nbuf_ctrl_if if0();
  nbuf_ctrl_if if1();

  nbuf_ctrl #(.NBUF(3), .MODE(0), .CNT_W(16)) dut0 (
    .fclk(fclk), .rst(rst), .start(start0), .FRAME_BYTES(FB), .BUF_BASE(BASE),
    .bus(if0.slave), .drop_count(drop0), .underrun_count(ur0), .ready_count(rc0));

  nbuf_ctrl #(.NBUF(4), .MODE(1), .CNT_W(16)) dut1 (
    .fclk(fclk), .rst(rst), .start(start1), .FRAME_BYTES(FB), .BUF_BASE(BASE),
    .bus(if1.slave), .drop_count(drop1), .underrun_count(ur1), .ready_count(rc1));

  always #5 fclk = ~fclk;

  typedef struct {
    logic [3:0]  in;   // {wr_sync, wr_frame_ready, rd_sync, rd_frame_ready}
    logic [3:0]  pls;  // {wr_frame_valid, wr_frame_done, rd_frame_valid, rd_frame_done}
    logic [31:0] wa, ra;
    int          rc, drop, ur;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;

  function automatic vec_t mk(input logic [3:0] in, input logic [3:0] pls, input logic [31:0] wa,
                              input logic [31:0] ra, input int rc, input int drop, input int ur);
    vec_t v;
    v.in = in; v.pls = pls; v.wa = wa; v.ra = ra; v.rc = rc; v.drop = drop; v.ur = ur;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input int sel, input logic [3:0] in);
    {if0.wr_sync, if0.wr_frame_ready, if0.rd_sync, if0.rd_frame_ready} = (sel == 0) ? in : 4'b0000;
    {if1.wr_sync, if1.wr_frame_ready, if1.rd_sync, if1.rd_frame_ready} = (sel == 1) ? in : 4'b0000;
  endtask

  // Drive after the falling edge, compare 1 time unit before the next rising edge.
  task automatic run_vec(input int sel, input string tag, input int row, input vec_t v);
    logic [3:0]  pls;
    logic [31:0] wa, ra, fb;
    int          rc, drop, ur;
    @(negedge fclk);
    drive(sel, v.in);
    #4;
    if (sel == 0) begin
      pls = {if0.wr_frame_valid, if0.wr_frame_done, if0.rd_frame_valid, if0.rd_frame_done};
      wa = if0.wr_BUF_ADDR; ra = if0.rd_BUF_ADDR; fb = if0.rd_FRAME_BYTES;
      rc = int'(rc0); drop = int'(drop0); ur = int'(ur0);
    end else begin
      pls = {if1.wr_frame_valid, if1.wr_frame_done, if1.rd_frame_valid, if1.rd_frame_done};
      wa = if1.wr_BUF_ADDR; ra = if1.rd_BUF_ADDR; fb = if1.wr_FRAME_BYTES;
      rc = int'(rc1); drop = int'(drop1); ur = int'(ur1);
    end
    chk($sformatf("%s[%0d].pulses(wv,wd,rv,rd)", tag, row), 32'(pls), 32'(v.pls));
    chk($sformatf("%s[%0d].wr_BUF_ADDR", tag, row), wa, v.wa);
    chk($sformatf("%s[%0d].rd_BUF_ADDR", tag, row), ra, v.ra);
    chk($sformatf("%s[%0d].ready_count", tag, row), 32'(rc), 32'(v.rc));
    chk($sformatf("%s[%0d].drop_count", tag, row), 32'(drop), 32'(v.drop));
    chk($sformatf("%s[%0d].underrun_count", tag, row), 32'(ur), 32'(v.ur));
    if (row == 0) chk($sformatf("%s.FRAME_BYTES", tag), fb, FB);
    $display("%s[%0d] in=%b pulses=%b wa=%h ra=%h rc=%0d drop=%0d ur=%0d",
             tag, row, v.in, pls, wa, ra, rc, drop, ur);
  endtask

  vec_t t0 [16];
  vec_t t1 [23];
  vec_t t2 [9];

  initial begin
    // MODE=0 NBUF=3: underruns, interleaved grants (buffers 0,1,2), drop, same-cycle done+pop.
    t0[0]  = mk(4'b0000, 4'b0000, A0, A0, 0, 0, 0);
    t0[1]  = mk(4'b0011, 4'b0000, A0, A0, 0, 0, 0);
    t0[2]  = mk(4'b0011, 4'b0000, A0, A0, 0, 0, 1);
    t0[3]  = mk(4'b0011, 4'b0000, A0, A0, 0, 0, 2);
    t0[4]  = mk(4'b1100, 4'b1000, A0, A0, 0, 0, 3);
    t0[5]  = mk(4'b0100, 4'b0100, A0, A0, 0, 0, 3);
    t0[6]  = mk(4'b1111, 4'b1010, A0, A0, 1, 0, 3);
    t0[7]  = mk(4'b0100, 4'b0100, A1, A0, 0, 0, 3);
    t0[8]  = mk(4'b1100, 4'b1000, A1, A0, 1, 0, 3);
    t0[9]  = mk(4'b0100, 4'b0100, A2, A0, 1, 0, 3);
    t0[10] = mk(4'b0001, 4'b0001, A2, A0, 1, 1, 3);
    t0[11] = mk(4'b1100, 4'b1000, A2, A0, 1, 1, 3);
    t0[12] = mk(4'b0111, 4'b0110, A0, A0, 1, 1, 3);
    t0[13] = mk(4'b0000, 4'b0000, A0, A2, 1, 1, 3);
    t0[14] = mk(4'b0001, 4'b0001, A0, A2, 1, 1, 3);
    t0[15] = mk(4'b0000, 4'b0000, A0, A2, 1, 1, 3);

    // MODE=1 NBUF=4: fill all buffers, writer stalls, reads come out 0,1,2,3,0.
    t1[0]  = mk(4'b0000, 4'b0000, A0, A0, 0, 0, 0);
    t1[1]  = mk(4'b1100, 4'b1000, A0, A0, 0, 0, 0);
    t1[2]  = mk(4'b0100, 4'b0100, A0, A0, 0, 0, 0);
    t1[3]  = mk(4'b1100, 4'b1000, A0, A0, 1, 0, 0);
    t1[4]  = mk(4'b0100, 4'b0100, A1, A0, 1, 0, 0);
    t1[5]  = mk(4'b1100, 4'b1000, A1, A0, 2, 0, 0);
    t1[6]  = mk(4'b0100, 4'b0100, A2, A0, 2, 0, 0);
    t1[7]  = mk(4'b1100, 4'b1000, A2, A0, 3, 0, 0);
    t1[8]  = mk(4'b0100, 4'b0100, A3, A0, 3, 0, 0);
    t1[9]  = mk(4'b1100, 4'b0000, A3, A0, 4, 0, 0);
    t1[10] = mk(4'b1111, 4'b0010, A3, A0, 4, 0, 0);
    t1[11] = mk(4'b1101, 4'b0001, A3, A0, 3, 0, 0);
    t1[12] = mk(4'b1111, 4'b1010, A3, A0, 3, 0, 0);
    t1[13] = mk(4'b0101, 4'b0101, A0, A1, 2, 0, 0);
    t1[14] = mk(4'b0011, 4'b0010, A0, A1, 3, 0, 0);
    t1[15] = mk(4'b0001, 4'b0001, A0, A2, 2, 0, 0);
    t1[16] = mk(4'b0011, 4'b0010, A0, A2, 2, 0, 0);
    t1[17] = mk(4'b0001, 4'b0001, A0, A3, 1, 0, 0);
    t1[18] = mk(4'b0011, 4'b0010, A0, A3, 1, 0, 0);
    t1[19] = mk(4'b0000, 4'b0000, A0, A0, 0, 0, 0);
    t1[20] = mk(4'b0001, 4'b0001, A0, A0, 0, 0, 0);
    t1[21] = mk(4'b0011, 4'b0000, A0, A0, 0, 0, 0);
    t1[22] = mk(4'b0000, 4'b0000, A0, A0, 0, 0, 1);

    // MODE=0 after reset: three frames with reader idle, then the reader takes the newest.
    t2[0] = mk(4'b0000, 4'b0000, A0, A0, 0, 0, 0);
    t2[1] = mk(4'b1100, 4'b1000, A0, A0, 0, 0, 0);
    t2[2] = mk(4'b0100, 4'b0100, A0, A0, 0, 0, 0);
    t2[3] = mk(4'b1100, 4'b1000, A0, A0, 1, 0, 0);
    t2[4] = mk(4'b0100, 4'b0100, A1, A0, 1, 0, 0);
    t2[5] = mk(4'b1100, 4'b1000, A1, A0, 1, 1, 0);
    t2[6] = mk(4'b0100, 4'b0100, A0, A0, 1, 1, 0);
    t2[7] = mk(4'b0011, 4'b0010, A0, A0, 1, 2, 0);
    t2[8] = mk(4'b0000, 4'b0000, A0, A0, 0, 2, 0);

    drive(0, 4'b0000);
    repeat (2) @(negedge fclk);
    rst = 1'b0;
    start0 = 1'b1;
    start1 = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(0, "m0", i, t0[i]);
    for (int i = 0; i < 23; i++) run_vec(1, "m1", i, t1[i]);

    // Put both sides of dut0 in WORKING, then assert reset mid-cycle.
    @(negedge fclk);
    drive(0, 4'b1111);
    @(negedge fclk);
    drive(0, 4'b0101);
    #2;
    chk("pre_rst.wr_frame_done", 32'(if0.wr_frame_done), 32'd1);
    chk("pre_rst.rd_frame_done", 32'(if0.rd_frame_done), 32'd1);
    chk("pre_rst.wr_BUF_ADDR", if0.wr_BUF_ADDR, A1);
    rst = 1'b1;
    #1;
    chk("rst.wr_frame_done", 32'(if0.wr_frame_done), 32'd0);
    chk("rst.rd_frame_done", 32'(if0.rd_frame_done), 32'd0);
    chk("rst.wr_BUF_ADDR", if0.wr_BUF_ADDR, A0);
    chk("rst.rd_BUF_ADDR", if0.rd_BUF_ADDR, A0);
    chk("rst.ready_count", 32'(rc0), 32'd0);
    chk("rst.drop_count", 32'(drop0), 32'd0);
    chk("rst.underrun_count", 32'(ur0), 32'd0);
    $display("rst async: wd=%b rd=%b wa=%h rc=%0d drop=%0d ur=%0d",
             if0.wr_frame_done, if0.rd_frame_done, if0.wr_BUF_ADDR, rc0, drop0, ur0);
    @(negedge fclk);
    drive(0, 4'b0000);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(0, "m0r", i, t2[i]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish within 20000 time units");
    $fatal(1, "timeout");
  end
endmodule
